// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch display driver: status codes,
// digit count, 7-segment patterns and the converter state encoding.
package stopwatch_pkg;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_RUNNING = 2'b01;
    localparam logic [1:0] ST_PAUSED  = 2'b10;

    localparam int NUM_DIGITS = 4;

    // Active-high {g,f,e,d,c,b,a} patterns, entry 9 first so [d] selects digit d.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic [1:0] {
        CV_IDLE,
        CV_CAPTURE,
        CV_SHIFT,
        CV_COMMIT
    } cv_state_t;

    // Codes above 9 are not decimal digits and are shown blank.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        s = 7'h00;
        if (d <= 4'd9) begin
            s = SEG_TABLE[d];
        end
        return s;
    endfunction

endpackage

// File: rtl/stopwatch_display_driver_bin2bcd_seq.sv
// Sequential double-dabble: 8-bit binary to three BCD nibbles in 8 cycles.
// start loads the operand; done is high during the final shift cycle and
// bcd holds the finished result from the following cycle onward.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);

    // {hundreds, tens, units, remaining binary bits}
    logic [19:0] sr_reg;
    logic [19:0] adj;
    logic [2:0]  cnt_reg;
    logic        active_reg;

    assign adj[7:0] = sr_reg[7:0];

    // Add-3 correction on every BCD nibble that would overflow when doubled.
    for (genvar gi = 0; gi < 3; gi++) begin : g_adj
        assign adj[8 + 4*gi +: 4] = (sr_reg[8 + 4*gi +: 4] >= 4'd5)
                                    ? sr_reg[8 + 4*gi +: 4] + 4'd3
                                    : sr_reg[8 + 4*gi +: 4];
    end

    // Load on start, then eight correct-and-shift steps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_reg     <= '0;
            cnt_reg    <= '0;
            active_reg <= 1'b0;
        end else if (start) begin
            sr_reg     <= {12'd0, bin};
            cnt_reg    <= '0;
            active_reg <= 1'b1;
        end else if (active_reg) begin
            sr_reg  <= {adj[18:0], 1'b0};
            cnt_reg <= cnt_reg + 3'd1;
            if (cnt_reg == 3'd7) begin
                active_reg <= 1'b0;
            end
        end
    end

    assign busy = active_reg;
    assign done = active_reg && (cnt_reg == 3'd7);
    assign bcd  = sr_reg[19:8];

endmodule

// File: rtl/stopwatch_display_driver.sv
// Stopwatch display driver: snapshots minutes/seconds, converts them to BCD
// and scans a 4-digit multiplexed 7-segment display as MM.SS.
// Optional macro BLINK_EN: blank the digits periodically while PAUSED.
module stopwatch_display_driver
    import stopwatch_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int BLINK_LOG2     = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            minutes,
    input  logic [5:0]            seconds,
    input  logic [1:0]            status,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  busy,
    output logic                  min_ovf
);

    localparam int   PW  = $clog2(SCAN_DIV);
    localparam logic INV = (SEG_ACTIVE_LOW != 0);

    cv_state_t state_reg, state_next;
    logic        conv_start;
    logic [7:0]  snap_min_reg, snap_sec_reg;
    logic        snap_valid_reg;
    logic        sample_diff;
    logic [11:0] min_bcd, sec_bcd;
    logic        min_done;
    logic        unused_min_busy, unused_sec_busy, unused_sec_done;
    logic [3:0]  unused_sec_hund;

    logic [3:0]  digit_reg [NUM_DIGITS];
    logic        min_ovf_reg;
    logic        lit_reg;

    logic [PW-1:0]         presc_reg;
    logic [1:0]            idx_reg;
    logic                  tc;
    logic [NUM_DIGITS-1:0] digit_sel;
    logic                  blank;
    logic [NUM_DIGITS-1:0] an_reg;
    logic [6:0]            seg_reg;
    logic                  dp_reg;

    assign sample_diff     = {minutes, 2'b00, seconds} != {snap_min_reg, snap_sec_reg};
    assign unused_sec_hund = sec_bcd[11:8];

    bin2bcd_seq u_min_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .bin   (minutes),
        .busy  (unused_min_busy),
        .done  (min_done),
        .bcd   (min_bcd)
    );

    bin2bcd_seq u_sec_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .bin   ({2'b00, seconds}),
        .busy  (unused_sec_busy),
        .done  (unused_sec_done),
        .bcd   (sec_bcd)
    );

    // Converter state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= CV_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Converter next state and control strobes.
    always_comb begin
        state_next = state_reg;
        conv_start = 1'b0;
        busy       = 1'b0;
        unique case (state_reg)
            CV_IDLE: begin
                if (!snap_valid_reg || sample_diff) begin
                    state_next = CV_CAPTURE;
                end
            end
            CV_CAPTURE: begin
                conv_start = 1'b1;
                busy       = 1'b1;
                state_next = CV_SHIFT;
            end
            CV_SHIFT: begin
                busy = 1'b1;
                if (min_done) begin
                    state_next = CV_COMMIT;
                end
            end
            CV_COMMIT: begin
                state_next = CV_IDLE;
            end
            default: begin
                state_next = CV_IDLE;
            end
        endcase
    end

    // Snapshot of the value being converted, used to detect new input.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            snap_min_reg   <= '0;
            snap_sec_reg   <= '0;
            snap_valid_reg <= 1'b0;
        end else if (state_reg == CV_CAPTURE) begin
            snap_min_reg   <= minutes;
            snap_sec_reg   <= {2'b00, seconds};
            snap_valid_reg <= 1'b1;
        end
    end

    // All four digits and the overflow flag change together at commit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_reg[i] <= '0;
            end
            min_ovf_reg <= 1'b0;
            lit_reg     <= 1'b0;
        end else if (state_reg == CV_COMMIT) begin
            digit_reg[0] <= sec_bcd[3:0];
            digit_reg[1] <= sec_bcd[7:4];
            digit_reg[2] <= min_bcd[3:0];
            digit_reg[3] <= min_bcd[7:4];
            min_ovf_reg  <= (min_bcd[11:8] != 4'd0);
            lit_reg      <= 1'b1;
        end
    end

    assign min_ovf = min_ovf_reg;
    assign tc      = (presc_reg == PW'(SCAN_DIV - 1));

    // Digit-slot prescaler and scan index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_reg <= '0;
            idx_reg   <= '0;
        end else if (tc) begin
            presc_reg <= '0;
            idx_reg   <= idx_reg + 2'd1;
        end else begin
            presc_reg <= presc_reg + PW'(1);
        end
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_sel
        assign digit_sel[gi] = (idx_reg == 2'(gi));
    end

`ifdef BLINK_EN
    logic [BLINK_LOG2-1:0] frame_cnt_reg;
    logic                  phase_reg;
    logic                  blank_reg;
    logic                  frame_end;
    logic                  phase_next;

    assign frame_end  = tc && (idx_reg == 2'd3);
    assign phase_next = phase_reg ^ (frame_end && (&frame_cnt_reg));

    // Frame counter and blink phase; blanking is resampled only at slot edges.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt_reg <= '0;
            phase_reg     <= 1'b0;
            blank_reg     <= 1'b0;
        end else begin
            if (frame_end) begin
                frame_cnt_reg <= frame_cnt_reg + 1'b1;
            end
            phase_reg <= phase_next;
            if (tc) begin
                blank_reg <= (status == ST_PAUSED) && phase_next;
            end
        end
    end

    assign blank = blank_reg;
`else
    localparam int unused_blink_log2 = BLINK_LOG2;
    logic unused_status;
    assign unused_status = ^status;
    assign blank         = 1'b0;
`endif

    // Pin-level output registers with polarity applied.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an_reg  <= {NUM_DIGITS{INV}};
            seg_reg <= {7{INV}};
            dp_reg  <= INV;
        end else begin
            an_reg  <= ((lit_reg && !blank) ? digit_sel : '0) ^ {NUM_DIGITS{INV}};
            seg_reg <= (lit_reg ? bcd_to_seg(digit_reg[idx_reg]) : 7'h00) ^ {7{INV}};
            dp_reg  <= (lit_reg && (idx_reg == 2'd2)) ^ INV;
        end
    end

    assign an  = an_reg;
    assign seg = seg_reg;
    assign dp  = dp_reg;

endmodule

// File: tb/tb_stopwatch_display_driver.sv
// Directed bench for stopwatch_display_driver (SCAN_DIV=4, active-low pins).
module tb_stopwatch_display_driver;

    localparam int SCAN_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] minutes;
    logic [5:0] seconds;
    logic [1:0] status;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       busy;
    logic       min_ovf;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_ref [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    stopwatch_display_driver #(
        .SCAN_DIV       (SCAN_DIV),
        .SEG_ACTIVE_LOW (1),
        .BLINK_LOG2     (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .minutes (minutes),
        .seconds (seconds),
        .status  (status),
        .an      (an),
        .seg     (seg),
        .dp      (dp),
        .busy    (busy),
        .min_ovf (min_ovf)
    );

    always #5 clk = ~clk;

    task automatic check_bit(input logic obs, input logic exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_blank(input string tag);
        checks++;
        assert (an === 4'b1111 && seg === 7'h7F && dp === 1'b1) else begin
            errors++;
            $error("FAIL %s observed an=%b seg=%h dp=%b expected an=1111 seg=7f dp=1",
                   tag, an, seg, dp);
        end
    endtask

    // Called right after the input change (or reset release) is driven:
    // busy high for the next 9 cycles, low on the 10th (commit), then settle.
    task automatic expect_conversion(input logic blank_before, input string tag);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            check_bit(busy, (c <= 9), $sformatf("%s_busy_c%0d", tag, c));
            if (blank_before) check_blank($sformatf("%s_blank_c%0d", tag, c));
        end
        repeat (2) @(negedge clk);
        $display("conversion %s done: min=%0d sec=%0d", tag, minutes, seconds);
    endtask

    // Observe 24 cycles of scanning; every lit digit must carry its pattern,
    // slots rotate 0->1->2->3 and each full slot lasts SCAN_DIV cycles.
    task automatic check_scan(input logic [3:0] d0, input logic [3:0] d1,
                              input logic [3:0] d2, input logic [3:0] d3,
                              input string tag);
        logic [3:0] dg [4];
        int k, prev_k, run, changes;
        dg = '{d0, d1, d2, d3};
        prev_k = -1; run = 0; changes = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            k = -1;
            for (int j = 0; j < 4; j++) if (an === ~(4'b0001 << j)) k = j;
            checks++;
            assert (k >= 0) else begin
                errors++;
                $error("FAIL %s_an observed=%b expected=one-hot-low", tag, an);
            end
            if (k >= 0) begin
                checks++;
                assert (seg === ~seg_ref[dg[k]]) else begin
                    errors++;
                    $error("FAIL %s_seg%0d observed=%h expected=%h", tag, k, seg, ~seg_ref[dg[k]]);
                end
                check_bit(dp, (k != 2), $sformatf("%s_dp%0d", tag, k));
                if (prev_k >= 0 && k != prev_k) begin
                    checks++;
                    assert (k == (prev_k + 1) % 4) else begin
                        errors++;
                        $error("FAIL %s_order observed=%0d expected=%0d", tag, k, (prev_k + 1) % 4);
                    end
                    if (changes > 0) begin
                        checks++;
                        assert (run == SCAN_DIV) else begin
                            errors++;
                            $error("FAIL %s_slot_len observed=%0d expected=%0d", tag, run, SCAN_DIV);
                        end
                    end
                    changes++;
                    run = 0;
                end
                prev_k = k;
                run++;
            end
        end
        checks++;
        assert (changes >= 4) else begin
            errors++;
            $error("FAIL %s_scan_moves observed=%0d expected>=4", tag, changes);
        end
        $display("scan %s: digits %0d%0d.%0d%0d checked", tag, d3, d2, d1, d0);
    endtask

    initial begin
        int  commits;
        logic prev_busy;

        rst_n   = 1'b0;
        minutes = 8'd0;
        seconds = 6'd0;
        status  = 2'b00;

        // Reset state.
        repeat (3) @(negedge clk);
        check_blank("reset_pins");
        check_bit(busy, 1'b0, "reset_busy");
        check_bit(min_ovf, 1'b0, "reset_min_ovf");

        // First conversion starts on release; display stays blank until commit.
        rst_n = 1'b1;
        expect_conversion(1'b1, "release");
        check_scan(4'd0, 4'd0, 4'd0, 4'd0, "zeros");

        // 12:34
        minutes = 8'd12; seconds = 6'd34;
        expect_conversion(1'b0, "12_34");
        check_bit(min_ovf, 1'b0, "12_34_min_ovf");
        check_scan(4'd4, 4'd3, 4'd2, 4'd1, "12_34");

        // 123:59 shows 23.59 with overflow.
        minutes = 8'd123; seconds = 6'd59;
        expect_conversion(1'b0, "123_59");
        check_bit(min_ovf, 1'b1, "123_59_min_ovf");
        check_scan(4'd9, 4'd5, 4'd3, 4'd2, "123_59");

        // 99 minutes clears the overflow.
        minutes = 8'd99;
        expect_conversion(1'b0, "99_59");
        check_bit(min_ovf, 1'b0, "99_59_min_ovf");
        check_scan(4'd9, 4'd5, 4'd9, 4'd9, "99_59");

        // Out-of-range seconds convert literally.
        minutes = 8'd0; seconds = 6'd63;
        expect_conversion(1'b0, "00_63");
        check_scan(4'd3, 4'd6, 4'd0, 4'd0, "00_63");

        // Seconds change every cycle for 20 cycles.
        minutes = 8'd5; seconds = 6'd40;
        expect_conversion(1'b0, "05_40");
        commits   = 0;
        prev_busy = busy;
        for (int i = 0; i < 20; i++) begin
            seconds = 6'(i);
            @(negedge clk);
            if (prev_busy && !busy) commits++;
            prev_busy = busy;
        end
        checks++;
        assert (commits >= 1 && commits <= 2) else begin
            errors++;
            $error("FAIL burst_commits observed=%0d expected=1..2", commits);
        end
        $display("burst: %0d commits during 20 changing cycles", commits);
        repeat (25) @(negedge clk);
        check_bit(busy, 1'b0, "burst_settled_busy");
        check_scan(4'd9, 4'd1, 4'd5, 4'd0, "burst_final");

        // Reset during SHIFT cycle 4 aborts and clears everything.
        minutes = 8'd150; seconds = 6'd7;
        expect_conversion(1'b0, "150_07");
        check_bit(min_ovf, 1'b1, "150_07_min_ovf");
        seconds = 6'd8;
        repeat (5) @(negedge clk);
        check_bit(busy, 1'b1, "abort_busy_before");
        rst_n = 1'b0;
        @(negedge clk);
        check_bit(busy, 1'b0, "abort_busy");
        check_bit(min_ovf, 1'b0, "abort_min_ovf");
        check_blank("abort_pins");
        rst_n = 1'b1;
        expect_conversion(1'b1, "after_abort");
        check_bit(min_ovf, 1'b1, "after_abort_min_ovf");
        check_scan(4'd8, 4'd0, 4'd0, 4'd5, "after_abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
